// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Used by the transmit arbiter and its helpers.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } uart_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: returns the first requester strictly
// after rr_ptr (wrapping). Generic, shared by other shared-resource arbiters.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand_s;

  // Scan offsets 1..NUM_REQ from the pointer; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
      index  = (!valid && req[cand_s]) ? cand_s : index;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin per byte,
// per packet while req_last is low, with a watchdog against a lost done.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WATCHDOG_CLOCKS = 65535,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           uart_send,
  output logic [UART_BYTE_W-1:0]         uart_byte,
  input  logic                           uart_done,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_id,
  output logic                           error
);

  localparam int WD_W = (WATCHDOG_CLOCKS > 0) ? $clog2(WATCHDOG_CLOCKS + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WATCHDOG_CLOCKS > 0) ? WATCHDOG_CLOCKS - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};
  localparam logic WD_ON = (WATCHDOG_CLOCKS > 0) ? 1'b1 : 1'b0;
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  uart_arb_state_e        state_r, state_s;
  logic [NUM_REQ-1:0]     ack_r, ack_s;
  logic                   send_r, send_s;
  logic [UART_BYTE_W-1:0] byte_r, byte_s;
  logic                   busy_r, busy_s;
  logic [IDX_W-1:0]       grant_r, grant_s;
  logic                   error_r, error_s;
  logic                   lock_r, lock_s;
  logic [IDX_W-1:0]       rr_ptr_r, rr_s;
  logic [WD_W-1:0]        wd_cnt_r, wd_s;

  logic                   pick_valid_s;
  logic [IDX_W-1:0]       pick_index_s;
  logic                   hold_owner_s;
  logic                   launch_s;
  logic [IDX_W-1:0]       gnt_idx_s;
  logic [UART_BYTE_W-1:0] req_bytes_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes_s[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .index  (pick_index_s)
  );

  // Next-state and next-output logic for the grant/issue/wait sequence.
  always_comb begin
    state_s      = state_r;
    ack_s        = '0;
    send_s       = 1'b0;
    byte_s       = byte_r;
    busy_s       = busy_r;
    grant_s      = grant_r;
    error_s      = 1'b0;
    lock_s       = lock_r;
    rr_s         = rr_ptr_r;
    wd_s         = wd_cnt_r;
    hold_owner_s = lock_r & req[grant_r];
    launch_s     = hold_owner_s | pick_valid_s;
    gnt_idx_s    = hold_owner_s ? grant_r : pick_index_s;

    case (state_r)
      IDLE: begin
        // A lock whose owner has gone quiet is released in the same cycle.
        lock_s = hold_owner_s;
        if (launch_s) begin
          grant_s = gnt_idx_s;
          byte_s  = req_bytes_s[gnt_idx_s];
          send_s  = 1'b1;
          busy_s  = 1'b1;
          state_s = ISSUE;
        end else begin
          busy_s  = 1'b0;
        end
      end
      ISSUE: begin
        wd_s    = '0;
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_done) begin
          ack_s[grant_r] = 1'b1;
          rr_s           = grant_r;
          lock_s         = ~req_last[grant_r];
          busy_s         = 1'b0;
          state_s        = IDLE;
        end else if (WD_ON && (wd_cnt_r == WD_LAST)) begin
          error_s = 1'b1;
          lock_s  = 1'b0;
          rr_s    = grant_r;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          wd_s = (wd_cnt_r == WD_MAX) ? wd_cnt_r : wd_cnt_r + WD_W'(1);
        end
      end
      default: begin
        lock_s  = 1'b0;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      ack_r    <= '0;
      send_r   <= 1'b0;
      byte_r   <= '0;
      busy_r   <= 1'b0;
      grant_r  <= '0;
      error_r  <= 1'b0;
      lock_r   <= 1'b0;
      rr_ptr_r <= RR_RESET;
      wd_cnt_r <= '0;
    end else begin
      state_r  <= state_s;
      ack_r    <= ack_s;
      send_r   <= send_s;
      byte_r   <= byte_s;
      busy_r   <= busy_s;
      grant_r  <= grant_s;
      error_r  <= error_s;
      lock_r   <= lock_s;
      rr_ptr_r <= rr_s;
      wd_cnt_r <= wd_s;
    end
  end

  assign ack       = ack_r;
  assign uart_send = send_r;
  assign uart_byte = byte_r;
  assign busy      = busy_r;
  assign grant_id  = grant_r;
  assign error     = error_r;

endmodule
